// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
package tts_pkg;

  typedef enum logic [1:0] {StIdle, StHold, StDone} state_e;

  function automatic int unsigned nvec(input int unsigned n);
    return 32'd1 << n;
  endfunction

  function automatic int unsigned tt_width(input int unsigned n, input int unsigned m);
    return m * nvec(n);
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control, stimulus/response and result bundle between a sweeper and its environment.
interface truth_table_sweeper_if #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned M_OUT = 1
);
  import tts_pkg::*;

  localparam int unsigned TtW = tt_width(N_IN, M_OUT);

  logic              start;
  logic              abort;
  logic [N_IN-1:0]   stim;
  logic [M_OUT-1:0]  resp;
  logic [TtW-1:0]    exp_tt;
  logic              busy;
  logic              done;
  logic [TtW-1:0]    tt_out;
  logic [N_IN:0]     mismatch_cnt;
  logic              first_fail_vld;
  logic [N_IN-1:0]   first_fail_idx;

  modport master (
    output start, abort, resp, exp_tt,
    input  stim, busy, done, tt_out, mismatch_cnt, first_fail_vld, first_fail_idx
  );

  modport slave (
    input  start, abort, resp, exp_tt,
    output stim, busy, done, tt_out, mismatch_cnt, first_fail_vld, first_fail_idx
  );

endinterface

// File: rtl/truth_table_sweeper_settle.sv
// Loadable settle down-counter; expire is high while the count sits at zero.
module tts_settle_timer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  if (SETTLE == 0) begin : g_none
    // No hold cycles: every cycle is a sampling cycle, so no state is needed.
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, load, en};
    assign expire = 1'b1;
  end else begin : g_cnt
    localparam int unsigned CntW = $clog2(SETTLE + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (load) begin
        cnt_d = CntW'(SETTLE);
      end else if (en && (cnt_q != '0)) begin
        cnt_d = cnt_q - CntW'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign expire = (cnt_q == '0);
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive input sweeper: drives every vector, captures responses, scores them.
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned M_OUT  = 1,
  parameter int unsigned SETTLE = 1
) (
  input logic                 clk,
  input logic                 rst,
  truth_table_sweeper_if.slave bus
);

  localparam int unsigned NVEC = nvec(N_IN);
  localparam int unsigned TtW  = tt_width(N_IN, M_OUT);
  localparam int unsigned CntW = N_IN + 1;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [TtW-1:0]    tt_q, tt_d;
  logic [CntW-1:0]   mm_q, mm_d;
  logic              ff_vld_q, ff_vld_d;
  logic [N_IN-1:0]   ff_idx_q, ff_idx_d;
  logic              expire, go, last, sample, abort_now;
  int unsigned       base;

  assign go        = bus.start && (state_q != StHold);
  assign last      = (idx_q == N_IN'(NVEC - 1));
  assign abort_now = (state_q == StHold) && bus.abort;
  // Abort wins over a coincident sampling edge, discarding that sample.
  assign sample    = (state_q == StHold) && !bus.abort && expire;
  assign base      = 32'(idx_q) * M_OUT;

  tts_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (go || (sample && !last)),
    .en     (state_q == StHold),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StHold;
      StHold: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (expire && last) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = bus.start ? StHold : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == StHold);
    bus.done = (state_q == StDone);
  end

  always_comb begin
    idx_d    = idx_q;
    tt_d     = tt_q;
    mm_d     = mm_q;
    ff_vld_d = ff_vld_q;
    ff_idx_d = ff_idx_q;
    if (go) begin
      idx_d    = '0;
      tt_d     = '0;
      mm_d     = '0;
      ff_vld_d = 1'b0;
      ff_idx_d = '0;
    end else if (abort_now) begin
      idx_d = '0;
    end else if (sample) begin
      tt_d[base +: M_OUT] = bus.resp;
      if (bus.resp != bus.exp_tt[base +: M_OUT]) begin
        mm_d = mm_q + CntW'(1);
        if (!ff_vld_q) begin
          ff_vld_d = 1'b1;
          ff_idx_d = idx_q;
        end
      end
      if (!last) begin
        idx_d = idx_q + N_IN'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      tt_q     <= '0;
      mm_q     <= '0;
      ff_vld_q <= 1'b0;
      ff_idx_q <= '0;
    end else begin
      idx_q    <= idx_d;
      tt_q     <= tt_d;
      mm_q     <= mm_d;
      ff_vld_q <= ff_vld_d;
      ff_idx_q <= ff_idx_d;
    end
  end

  assign bus.stim           = idx_q;
  assign bus.tt_out         = tt_q;
  assign bus.mismatch_cnt   = mm_q;
  assign bus.first_fail_vld = ff_vld_q;
  assign bus.first_fail_idx = ff_idx_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: randomized expected tables scored against a behavioural model.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  bit   fsel;  // 0: majority DUT, 1: XOR3 DUT

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(3), .M_OUT(1)) ia ();
  truth_table_sweeper_if #(.N_IN(4), .M_OUT(2)) ib ();

  assign ia.resp = fsel ? (^ia.stim) : ($countones(ia.stim) >= 2);
  assign ib.resp = {ib.stim[3] & ib.stim[2], ib.stim[1] | ib.stim[0]};

  truth_table_sweeper #(.N_IN(3), .M_OUT(1), .SETTLE(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia.slave)
  );

  truth_table_sweeper #(.N_IN(4), .M_OUT(2), .SETTLE(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib.slave)
  );

  function automatic logic [7:0] ref_a(input bit xor_dut);
    logic [7:0] t;
    for (int k = 0; k < 8; k++) begin
      t[k] = xor_dut ? ($countones(k) % 2 == 1) : ($countones(k) >= 2);
    end
    return t;
  endfunction

  function automatic logic [31:0] ref_b();
    logic [31:0] t;
    for (int k = 0; k < 16; k++) begin
      t[2*k+1] = (k >= 12);
      t[2*k]   = (k % 4 != 0);
    end
    return t;
  endfunction

  // Scores a captured table against an expected one, M bits per vector.
  function automatic void score(input logic [31:0] got, input logic [31:0] exp, input int nv,
                                input int m, output int cnt, output int first);
    cnt   = 0;
    first = -1;
    for (int k = 0; k < nv; k++) begin
      if (((got >> (k * m)) & ((32'd1 << m) - 1)) != ((exp >> (k * m)) & ((32'd1 << m) - 1)))
      begin
        cnt++;
        if (first < 0) first = k;
      end
    end
  endfunction

  task automatic sweep_a(input int restart_at, input bit hold, output int done_at,
                         output int stim_err, output int busy_err);
    done_at  = -1;
    stim_err = 0;
    busy_err = 0;
    @(negedge clk);
    ia.start = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 64; j++) begin
      if (!hold) ia.start = (j == restart_at);
      if (ia.done) begin
        done_at = j;
        break;
      end
      if (ia.stim !== 3'(j / 2)) stim_err++;
      if (ia.busy !== 1'b1) busy_err++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (ia.busy !== 1'b0 || ia.done !== 1'b0 || ia.stim !== 3'd0) begin
      bad++;
      $display("FAIL reset_ctrl_a: busy=%b done=%b stim=%0d, want 0 0 0", ia.busy, ia.done,
               ia.stim);
    end
    total++;
    if (ia.tt_out !== 8'h0 || ia.mismatch_cnt !== 4'd0 || ia.first_fail_vld !== 1'b0 ||
        ia.first_fail_idx !== 3'd0) begin
      bad++;
      $display("FAIL reset_res_a: tt=%h cnt=%0d vld=%b idx=%0d, want all 0", ia.tt_out,
               ia.mismatch_cnt, ia.first_fail_vld, ia.first_fail_idx);
    end
    total++;
    if (ib.busy !== 1'b0 || ib.done !== 1'b0 || ib.stim !== 4'd0 || ib.tt_out !== 32'h0 ||
        ib.mismatch_cnt !== 5'd0 || ib.first_fail_vld !== 1'b0) begin
      bad++;
      $display("FAIL reset_b: busy=%b done=%b stim=%0d tt=%h cnt=%0d, want all 0", ib.busy,
               ib.done, ib.stim, ib.tt_out, ib.mismatch_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_sweep(input bit xor_dut, input logic [7:0] exp, input string name);
    int d, se, be, cnt, first;
    fsel      = xor_dut;
    ia.exp_tt = exp;
    score({24'h0, ref_a(xor_dut)}, {24'h0, exp}, 8, 1, cnt, first);
    sweep_a(-1, 1'b0, d, se, be);
    total++;
    if (d !== 16 || se !== 0 || be !== 0) begin
      bad++;
      $display("FAIL %s_timing: done_at=%0d stim_err=%0d busy_err=%0d, want 16 0 0", name, d,
               se, be);
    end
    total++;
    if (ia.tt_out !== ref_a(xor_dut) || ia.stim !== 3'd7) begin
      bad++;
      $display("FAIL %s_table: tt=%h stim=%0d, want %h 7", name, ia.tt_out, ia.stim,
               ref_a(xor_dut));
    end
    total++;
    if (ia.mismatch_cnt !== 4'(cnt) || ia.first_fail_vld !== (first >= 0) ||
        ia.first_fail_idx !== 3'((first >= 0) ? first : 0)) begin
      bad++;
      $display("FAIL %s_score: cnt=%0d vld=%b idx=%0d, want %0d %b %0d", name, ia.mismatch_cnt,
               ia.first_fail_vld, ia.first_fail_idx, cnt, first >= 0, first);
    end
    @(negedge clk);
    total++;
    if (ia.done !== 1'b0 || ia.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_pulse: done=%b busy=%b one cycle later, want 0 0", name, ia.done,
               ia.busy);
    end
  endtask

  task automatic test_settle0();
    int d, se, cnt, first;
    logic [31:0] exp;
    for (int r = 0; r < 2; r++) begin
      exp = (r == 0) ? ref_b() : $urandom;
      ib.exp_tt = exp;
      score(ref_b(), exp, 16, 2, cnt, first);
      d  = -1;
      se = 0;
      @(negedge clk);
      ib.start = 1'b1;
      @(negedge clk);
      ib.start = 1'b0;
      for (int j = 0; j < 64; j++) begin
        if (ib.done) begin
          d = j;
          break;
        end
        if (ib.stim !== 4'(j) || ib.busy !== 1'b1) se++;
        @(negedge clk);
      end
      total++;
      if (d !== 16 || se !== 0) begin
        bad++;
        $display("FAIL settle0_timing_%0d: done_at=%0d stim_err=%0d, want 16 0", r, d, se);
      end
      total++;
      if (ib.tt_out !== ref_b()) begin
        bad++;
        $display("FAIL settle0_table_%0d: tt=%h, want %h", r, ib.tt_out, ref_b());
      end
      total++;
      if (ib.mismatch_cnt !== 5'(cnt) || ib.first_fail_vld !== (first >= 0) ||
          ib.first_fail_idx !== 4'((first >= 0) ? first : 0)) begin
        bad++;
        $display("FAIL settle0_score_%0d: cnt=%0d vld=%b idx=%0d, want %0d %b %0d", r,
                 ib.mismatch_cnt, ib.first_fail_vld, ib.first_fail_idx, cnt, first >= 0, first);
      end
    end
  endtask

  task automatic test_abort(input int v);
    int ph, dones;
    logic [7:0] want;
    fsel      = 1'b0;
    ia.exp_tt = 8'hE8;
    ph        = $urandom_range(0, 1);
    want      = ref_a(1'b0) & 8'((1 << v) - 1);
    @(negedge clk);
    ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    for (int j = 0; j < 2 * v + ph; j++) @(negedge clk);
    total++;
    if (ia.stim !== 3'(v)) begin
      bad++;
      $display("FAIL abort_pre_%0d: stim=%0d, want %0d", v, ia.stim, v);
    end
    ia.abort = 1'b1;
    @(negedge clk);
    ia.abort = 1'b0;
    total++;
    if (ia.busy !== 1'b0 || ia.done !== 1'b0 || ia.stim !== 3'd0 || ia.tt_out !== want) begin
      bad++;
      $display("FAIL abort_%0d: busy=%b done=%b stim=%0d tt=%h, want 0 0 0 %h", v, ia.busy,
               ia.done, ia.stim, ia.tt_out, want);
    end
    dones = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (ia.done) dones++;
    end
    total++;
    if (dones !== 0 || ia.tt_out !== want) begin
      bad++;
      $display("FAIL abort_after_%0d: done_pulses=%0d tt=%h, want 0 %h", v, dones, ia.tt_out,
               want);
    end
  endtask

  task automatic test_reset_mid();
    int d, se, be;
    fsel      = 1'b0;
    ia.exp_tt = 8'hE8;
    @(negedge clk);
    ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    for (int j = 0; j < 6; j++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (ia.busy !== 1'b0 || ia.done !== 1'b0 || ia.stim !== 3'd0 || ia.tt_out !== 8'h0 ||
        ia.mismatch_cnt !== 4'd0 || ia.first_fail_vld !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: busy=%b stim=%0d tt=%h cnt=%0d vld=%b, want all 0", ia.busy,
               ia.stim, ia.tt_out, ia.mismatch_cnt, ia.first_fail_vld);
    end
    #4 rst = 1'b0;
    sweep_a(5, 1'b0, d, se, be);
    total++;
    if (d !== 16 || se !== 0 || be !== 0 || ia.tt_out !== 8'hE8 || ia.mismatch_cnt !== 4'd0)
    begin
      bad++;
      $display("FAIL restart_ignored: done_at=%0d stim_err=%0d busy_err=%0d tt=%h cnt=%0d",
               d, se, be, ia.tt_out, ia.mismatch_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int d, se, be, d2;
    fsel      = 1'b1;
    ia.exp_tt = 8'hE8;
    sweep_a(-1, 1'b1, d, se, be);
    total++;
    if (d !== 16 || ia.tt_out !== 8'h96 || ia.mismatch_cnt !== 4'd6) begin
      bad++;
      $display("FAIL b2b_first: done_at=%0d tt=%h cnt=%0d, want 16 96 6", d, ia.tt_out,
               ia.mismatch_cnt);
    end
    @(negedge clk);
    total++;
    if (ia.busy !== 1'b1 || ia.done !== 1'b0 || ia.stim !== 3'd0 || ia.tt_out !== 8'h0 ||
        ia.mismatch_cnt !== 4'd0 || ia.first_fail_vld !== 1'b0) begin
      bad++;
      $display("FAIL b2b_clear: busy=%b done=%b stim=%0d tt=%h cnt=%0d vld=%b", ia.busy,
               ia.done, ia.stim, ia.tt_out, ia.mismatch_cnt, ia.first_fail_vld);
    end
    ia.start = 1'b0;
    d2 = -1;
    for (int j = 1; j < 64; j++) begin
      @(negedge clk);
      if (ia.done) begin
        d2 = j;
        break;
      end
    end
    total++;
    if (d2 !== 16 || ia.tt_out !== 8'h96 || ia.first_fail_idx !== 3'd1) begin
      bad++;
      $display("FAIL b2b_second: done_at=%0d tt=%h idx=%0d, want 16 96 1", d2, ia.tt_out,
               ia.first_fail_idx);
    end
  endtask

  initial begin
    rst       = 1'b1;
    fsel      = 1'b0;
    ia.start  = 1'b0;
    ia.abort  = 1'b0;
    ia.exp_tt = 8'hE8;
    ib.start  = 1'b0;
    ib.abort  = 1'b0;
    ib.exp_tt = '0;
    test_reset();
    test_sweep(1'b0, 8'hE8, "majority");
    test_sweep(1'b1, 8'hE8, "xor3");
    for (int r = 0; r < 4; r++) begin
      test_sweep(1'($urandom_range(0, 1)), 8'($urandom), "random_exp");
    end
    test_settle0();
    test_abort(5);
    test_abort($urandom_range(1, 7));
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
